// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types for the program-ROM arbiter.
//   arb_state_t : grant FSM state (PRIO0 = port 0 priority, FORCE1 = port 1 forced grant pending)
//   port_id_t   : requester tag (0 = CPU fetch, 1 = debug/UART readback)
//   rom_tag_t   : per-access tag carried alongside the ROM read latency
package rom_arb_pkg;

  typedef enum logic {PRIO0 = 1'b0, FORCE1 = 1'b1} arb_state_t;

  typedef logic port_id_t;

  typedef struct packed {
    logic     vld;
    port_id_t id;
  } rom_tag_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_DBG = 1'b1;

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// rom_arb_tag_pipe: ROM_LAT-deep shift register of access tags, matching the ROM read latency.
//   clk     : system clock
//   rst_n   : asynchronous active-low clear (all stages invalid)
//   tag_in  : tag of the access granted this cycle (loads stage 0)
//   tag_out : last stage, aligned with rom_data
module rom_arb_tag_pipe
  import rom_arb_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rom_tag_t tag_in,
  output rom_tag_t tag_out
);

  rom_tag_t tag_p [ROM_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) tag_p[i] <= '0;
    end else begin
      // stage 0 <- grant; stage i <- stage i-1
      tag_p[0] <= tag_in;
      for (int i = 1; i < ROM_LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign tag_out = tag_p[ROM_LAT-1];

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous-read program ROM between the CPU fetch port (port 0,
// priority) and the debug/UART readback port (port 1), with a starvation guard for port 1.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   p0_valid/p0_ready/p0_addr  : port 0 request handshake and address
//   p0_rvalid/p0_rdata         : port 0 response (single-cycle pulse, data held between pulses)
//   p1_*                       : same for port 1
//   rom_addr                   : address to the ROM (combinational from the grant, held when idle)
//   rom_data                   : ROM read data, ROM_LAT cycles after rom_addr is sampled
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 14,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic [DEPTH-1:0] p0_addr,
  output logic             p0_rvalid,
  output logic [WIDTH-1:0] p0_rdata,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic [DEPTH-1:0] p1_addr,
  output logic             p1_rvalid,
  output logic [WIDTH-1:0] p1_rdata,
  output logic [DEPTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data
);

  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             run;
  logic             gnt0, gnt1;
  logic [DEPTH-1:0] addr_hold;
  rom_tag_t         tag_in, tag_out;
  logic [WIDTH-1:0] rdata0_q, rdata1_q;

  // run rises one edge after reset release, so no request is accepted in the release cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run) begin
      if (state == FORCE1 && p1_valid) gnt1 = 1'b1;
      else if (p0_valid)               gnt0 = 1'b1;
      else if (p1_valid)               gnt1 = 1'b1;
    end
  end

  assign p0_ready = gnt0;
  assign p1_ready = gnt1;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    if (run) begin
      if (gnt1 || !p1_valid)                      wait_cnt_nxt = '0;
      else if (p0_valid && wait_cnt != WAIT_LIM)  wait_cnt_nxt = wait_cnt + 1'b1;
      // FORCE1 lasts one cycle: either port 1 takes its grant or it has withdrawn
      if (state == FORCE1)                state_nxt = PRIO0;
      else if (wait_cnt_nxt == WAIT_LIM)  state_nxt = FORCE1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PRIO0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign rom_addr = gnt1 ? p1_addr : (gnt0 ? p0_addr : addr_hold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            addr_hold <= '0;
    else if (gnt0 || gnt1) addr_hold <= rom_addr;
  end

  // stage 0: grant tag enters the latency pipeline alongside the ROM address
  assign tag_in.vld = gnt0 | gnt1;
  assign tag_in.id  = gnt1 ? PORT_DBG : PORT_CPU;

  rom_arb_tag_pipe #(
    .ROM_LAT (ROM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // last stage: steer rom_data to the tagged port; the idle port keeps its last word
  assign p0_rvalid = tag_out.vld && (tag_out.id == PORT_CPU);
  assign p1_rvalid = tag_out.vld && (tag_out.id == PORT_DBG);
  assign p0_rdata  = p0_rvalid ? rom_data : rdata0_q;
  assign p1_rdata  = p1_rvalid ? rom_data : rdata1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (p0_rvalid) rdata0_q <= rom_data;
      if (p1_rvalid) rdata1_q <= rom_data;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
`timescale 1ns/1ps
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             p0_valid = 1'b0;
  logic             p1_valid = 1'b0;
  logic [DEPTH-1:0] p0_addr = '0;
  logic [DEPTH-1:0] p1_addr = '0;
  logic             p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic [WIDTH-1:0] p0_rdata, p1_rdata;
  logic [DEPTH-1:0] rom_addr;
  logic [WIDTH-1:0] rom_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic r0, r1;
  logic [47:0] got, want;
  // entries are {cycle, data}: expected carries acceptance cycle + 1, observed the rvalid cycle
  logic [47:0] exp0[$], exp1[$], obs0[$], obs1[$];

  rom_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ROM_LAT(1), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // behavioural ROM, one cycle read latency
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= {2'b00, rom_addr} ^ 16'hA5A5;
  end

  function automatic logic [15:0] rom_model(input logic [13:0] a);
    return {2'b00, a} ^ 16'hA5A5;
  endfunction

  // one clock cycle: sample at negedge, record traffic, return just after the next posedge
  task automatic step();
    @(negedge clk);
    if (p0_rvalid) obs0.push_back({32'(cyc), p0_rdata});
    if (p1_rvalid) obs1.push_back({32'(cyc), p1_rdata});
    if (p0_valid && p0_ready) exp0.push_back({32'(cyc + 1), rom_model(p0_addr)});
    if (p1_valid && p1_ready) exp1.push_back({32'(cyc + 1), rom_model(p1_addr)});
    r0 = p0_ready;
    r1 = p1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; p0_valid = 1'b1; p0_addr = '0;
    step(); step();
    checks++;
    if ({r0, r1, p0_rvalid, p1_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: ready/rvalid=%b required 0000", {r0, r1, p0_rvalid, p1_rvalid});
    end
    checks++;
    if ({p0_rdata, p1_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h required 00000000", {p0_rdata, p1_rdata});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (r0 !== 1'b0) begin errors++; $display("FAIL release_cycle_ready: got %b required 0", r0); end
    step();
    checks++;
    if (r0 !== 1'b1) begin errors++; $display("FAIL first_ready: got %b required 1", r0); end
    p0_valid = 1'b0;
    step(); step();
    while (exp0.size() > 0 || obs0.size() > 0) begin
      got = '1; want = '1;
      if (obs0.size() > 0) got = obs0.pop_front();
      if (exp0.size() > 0) want = exp0.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL reset_p0_resp: got %h required %h", got, want); end
    end
  endtask

  task automatic test_port0_only();
    logic [13:0] addrs [4];
    addrs[0] = 14'h0000; addrs[1] = 14'h0001; addrs[2] = 14'h0002; addrs[3] = 14'h3FFF;
    for (int i = 0; i < 4; i++) begin
      p0_valid = 1'b1; p0_addr = addrs[i];
      step();
      checks++;
      if ({r0, r1} !== 2'b10) begin
        errors++; $display("FAIL port0_ready[%0d]: got %b required 10", i, {r0, r1});
      end
    end
    p0_valid = 1'b0;
    step(); step();
    while (exp0.size() > 0 || obs0.size() > 0) begin
      got = '1; want = '1;
      if (obs0.size() > 0) got = obs0.pop_front();
      if (exp0.size() > 0) want = exp0.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL port0_resp: got %h required %h", got, want); end
    end
    checks++;
    if (obs1.size() != 0) begin
      errors++; $display("FAIL port0_no_p1_rvalid: got %0d pulses required 0", obs1.size());
    end
    obs1.delete();
  endtask

  task automatic test_starvation();
    p0_valid = 1'b1; p1_valid = 1'b1; p1_addr = 14'h0010;
    for (int i = 0; i < 27; i++) begin
      p0_addr = 14'(i);
      step();
      checks++;
      if ({r0, r1} !== ((i % 9 == 8) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL starve_grant[%0d]: got %b required %b", i, {r0, r1},
                           (i % 9 == 8) ? 2'b01 : 2'b10);
      end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    step(); step();
    while (exp0.size() > 0 || obs0.size() > 0) begin
      got = '1; want = '1;
      if (obs0.size() > 0) got = obs0.pop_front();
      if (exp0.size() > 0) want = exp0.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL starve_p0_resp: got %h required %h", got, want); end
    end
    while (exp1.size() > 0 || obs1.size() > 0) begin
      got = '1; want = '1;
      if (obs1.size() > 0) got = obs1.pop_front();
      if (exp1.size() > 0) want = exp1.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL starve_p1_resp: got %h required %h", got, want); end
    end
    checks++;
    if (p1_rdata !== 16'hA5B5) begin errors++; $display("FAIL starve_p1_rdata: got %h required a5b5", p1_rdata); end
  endtask

  task automatic test_interleave();
    p1_valid = 1'b1; p1_addr = 14'h0003;
    step();
    checks++;
    if ({r0, r1} !== 2'b01) begin errors++; $display("FAIL inter_p1_ready: got %b required 01", {r0, r1}); end
    p1_valid = 1'b0; p0_valid = 1'b1; p0_addr = 14'h0004;
    step();
    checks++;
    if ({r0, r1} !== 2'b10) begin errors++; $display("FAIL inter_p0_ready: got %b required 10", {r0, r1}); end
    p0_valid = 1'b0;
    step(); step();
    checks++;
    if (obs1.size() != 1 || obs0.size() != 1 || obs0[0][47:16] !== obs1[0][47:16] + 32'd1) begin
      errors++; $display("FAIL inter_order: p1 pulses %0d p0 pulses %0d required 1 each, p0 one cycle after p1",
                         obs1.size(), obs0.size());
    end
    while (exp0.size() > 0 || obs0.size() > 0) begin
      got = '1; want = '1;
      if (obs0.size() > 0) got = obs0.pop_front();
      if (exp0.size() > 0) want = exp0.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL inter_p0_resp: got %h required %h", got, want); end
    end
    while (exp1.size() > 0 || obs1.size() > 0) begin
      got = '1; want = '1;
      if (obs1.size() > 0) got = obs1.pop_front();
      if (exp1.size() > 0) want = exp1.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL inter_p1_resp: got %h required %h", got, want); end
    end
  endtask

  task automatic test_midflight_reset();
    p1_valid = 1'b1; p1_addr = 14'h0005;
    step();
    checks++;
    if (r1 !== 1'b1) begin errors++; $display("FAIL mid_p1_ready: got %b required 1", r1); end
    rst_n = 1'b0; p1_valid = 1'b0;
    exp1.delete();
    step(); step();
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (obs1.size() != 0) begin
      errors++; $display("FAIL mid_no_rvalid: got %0d pulses required 0", obs1.size());
    end
    obs1.delete();
    checks++;
    if (dut.state !== PRIO0 || dut.wait_cnt !== '0) begin
      errors++; $display("FAIL mid_fsm: state/cnt %b/%0d required 0/0", dut.state, dut.wait_cnt);
    end
    checks++;
    if (p1_rdata !== 16'h0000) begin errors++; $display("FAIL mid_p1_rdata: got %h required 0000", p1_rdata); end
  endtask

  task automatic test_force1_abandon();
    p0_valid = 1'b1; p1_valid = 1'b1; p1_addr = 14'h0020;
    for (int i = 0; i < 8; i++) begin
      p0_addr = 14'(16 + i);
      step();
    end
    checks++;
    if (dut.state !== FORCE1) begin errors++; $display("FAIL abandon_reach: state %b required FORCE1", dut.state); end
    p1_valid = 1'b0; p0_addr = 14'h0100;
    step();
    checks++;
    if ({r0, r1} !== 2'b10) begin errors++; $display("FAIL abandon_grant: got %b required 10", {r0, r1}); end
    checks++;
    if (dut.state !== PRIO0) begin errors++; $display("FAIL abandon_state: state %b required PRIO0", dut.state); end
    p0_valid = 1'b0;
    step(); step();
    while (exp0.size() > 0 || obs0.size() > 0) begin
      got = '1; want = '1;
      if (obs0.size() > 0) got = obs0.pop_front();
      if (exp0.size() > 0) want = exp0.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL abandon_p0_resp: got %h required %h", got, want); end
    end
    checks++;
    if (obs1.size() != 0 || exp1.size() != 0) begin
      errors++; $display("FAIL abandon_p1: got %0d pulses required 0", obs1.size());
    end
  endtask

  initial begin
    test_reset();
    test_port0_only();
    test_starvation();
    test_interleave();
    test_midflight_reset();
    test_force1_abandon();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
